// File: rtl/tcu_fedp_seq_if.sv
// ---------------------------------------------------------------------------
// tcu_fedp_seq_if
//   Beat-input and result-output handshake bundle of the FEDP accumulation
//   sequencer.
//
//   Input beat port (valid/ready):
//     in_valid, in_ready, in_a_row, in_b_col, in_c_init, in_fmt_s, in_fmt_d,
//     in_vmask, in_tag, in_last
//   Result port (valid/ready):
//     out_valid, out_ready, out_data, out_tag, out_err
//
//   master : job producer / result consumer (testbench or upstream logic)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface tcu_fedp_seq_if #(
    parameter int N       = 2,
    parameter int TAG_W   = 8,
    parameter int VMASK_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*32-1:0]      in_a_row;
    logic [N*32-1:0]      in_b_col;
    logic [31:0]          in_c_init;
    logic [3:0]           in_fmt_s;
    logic [3:0]           in_fmt_d;
    logic [VMASK_W-1:0]   in_vmask;
    logic [TAG_W-1:0]     in_tag;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_data;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_err;

    modport master (
        output in_valid, in_a_row, in_b_col, in_c_init, in_fmt_s, in_fmt_d,
               in_vmask, in_tag, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_a_row, in_b_col, in_c_init, in_fmt_s, in_fmt_d,
               in_vmask, in_tag, in_last, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/tcu_fedp_seq.sv
// ---------------------------------------------------------------------------
// tcu_fedp_seq
//   Accumulation sequencer in front of a LATENCY-deep fused dot-product unit
//   (FEDP). A job arrives as a stream of K-chunk beats; each beat is issued
//   to the FEDP, and the FEDP result is fed back as the addend (c_val) of
//   the next beat, so the job yields one full-length dot product. The final
//   accumulator is returned with the job tag on a valid/ready port.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     bus (slave)       beat input port and result output port
//     fedp_enable       FEDP pipeline enable (tied high)
//     fedp_vld_mask     lane mask, non-zero only in the first issue cycle
//     fedp_fmt_s/_d     formats latched from the first beat of the job
//     fedp_a_row/_b_col operands of the beat being issued
//     fedp_c_val        addend: c_init for the first beat, accumulator after
//     fedp_d_val        FEDP result, LATENCY cycles after issue
//
//   Optional build macro TCU_FEDP_SEQ_PERF_EN adds perf_jobs (completed
//   result handshakes) and perf_stall (cycles stalled on out_ready in DONE
//   or on in_valid in ISSUE), both 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module tcu_fedp_seq #(
    parameter int N         = 2,
    parameter int LATENCY   = 4,
    parameter int MAX_STEPS = 8,
    parameter int TAG_W     = 8,
    parameter int VMASK_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    tcu_fedp_seq_if.slave       bus,
    output logic                fedp_enable,
    output logic [VMASK_W-1:0]  fedp_vld_mask,
    output logic [3:0]          fedp_fmt_s,
    output logic [3:0]          fedp_fmt_d,
    output logic [N*32-1:0]     fedp_a_row,
    output logic [N*32-1:0]     fedp_b_col,
    output logic [31:0]         fedp_c_val,
    input  logic [31:0]         fedp_d_val
`ifdef TCU_FEDP_SEQ_PERF_EN
    ,
    output logic [31:0]         perf_jobs,
    output logic [31:0]         perf_stall
`endif
);

    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [STEP_W-1:0]  step_cnt;
    logic               last_r;
    logic [31:0]        acc_r;
    logic [TAG_W-1:0]   tag_r;
    logic               accept;

    assign fedp_enable = 1'b1;
    assign accept      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            step_cnt      <= '0;
            last_r        <= 1'b0;
            acc_r         <= '0;
            tag_r         <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
            fedp_vld_mask <= '0;
            fedp_fmt_s    <= '0;
            fedp_fmt_d    <= '0;
            fedp_a_row    <= '0;
            fedp_b_col    <= '0;
            fedp_c_val    <= '0;
        end else begin
            case (state)
                IDLE, ISSUE: begin
                    if (accept) begin
                        fedp_a_row    <= bus.in_a_row;
                        fedp_b_col    <= bus.in_b_col;
                        fedp_vld_mask <= bus.in_vmask;
                        last_r        <= bus.in_last;
                        cnt           <= CNT_W'(LATENCY);
                        bus.in_ready  <= 1'b0;
                        state         <= WAIT;
                        if (state == IDLE) begin
                            // Job-level attributes come from the first beat only.
                            fedp_fmt_s <= bus.in_fmt_s;
                            fedp_fmt_d <= bus.in_fmt_d;
                            tag_r      <= bus.in_tag;
                            fedp_c_val <= bus.in_c_init;
                            step_cnt   <= STEP_W'(1);
                        end else begin
                            fedp_c_val <= acc_r;
                            step_cnt   <= step_cnt + STEP_W'(1);
                        end
                    end
                end
                WAIT: begin
                    // The FEDP samples the mask once; later cycles must not
                    // launch further valid lanes.
                    fedp_vld_mask <= '0;
                    if (cnt == '0) begin
                        acc_r <= fedp_d_val;
                        if (last_r || step_cnt == STEP_W'(MAX_STEPS)) begin
                            state <= DONE;
                        end else begin
                            state        <= ISSUE;
                            bus.in_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result, then hold until taken.
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= acc_r;
                        bus.out_tag   <= tag_r;
                        bus.out_err   <= (step_cnt == STEP_W'(MAX_STEPS)) && !last_r;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_err   <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef TCU_FEDP_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (state == DONE && bus.out_valid && bus.out_ready) begin
                perf_jobs <= perf_jobs + 32'd1;
            end
            if ((state == DONE && !bus.out_ready) || (state == ISSUE && !bus.in_valid)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcu_fedp_seq.sv
// ---------------------------------------------------------------------------
// tb_tcu_fedp_seq
//   Self-checking bench for tcu_fedp_seq. A behavioural FEDP (LATENCY-deep
//   pipeline computing c + sum(a*b) over masked lanes; fp32 when fmt_s==0,
//   32-bit wrapping integer otherwise) closes the loop. Expected job results
//   come from a running accumulation over the beats of each job.
// ---------------------------------------------------------------------------
module tb_tcu_fedp_seq;
    localparam int N         = 2;
    localparam int LATENCY   = 4;
    localparam int MAX_STEPS = 8;
    localparam int TAG_W     = 8;
    localparam int VMASK_W   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tcu_fedp_seq_if #(.N(N), .TAG_W(TAG_W), .VMASK_W(VMASK_W)) bus ();

    logic               fedp_enable;
    logic [VMASK_W-1:0] fedp_vld_mask;
    logic [3:0]         fedp_fmt_s;
    logic [3:0]         fedp_fmt_d;
    logic [N*32-1:0]    fedp_a_row;
    logic [N*32-1:0]    fedp_b_col;
    logic [31:0]        fedp_c_val;
    logic [31:0]        fedp_d_val;
`ifdef TCU_FEDP_SEQ_PERF_EN
    logic [31:0]        perf_jobs;
    logic [31:0]        perf_stall;
`endif

    tcu_fedp_seq #(
        .N(N), .LATENCY(LATENCY), .MAX_STEPS(MAX_STEPS), .TAG_W(TAG_W), .VMASK_W(VMASK_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .fedp_enable   (fedp_enable),
        .fedp_vld_mask (fedp_vld_mask),
        .fedp_fmt_s    (fedp_fmt_s),
        .fedp_fmt_d    (fedp_fmt_d),
        .fedp_a_row    (fedp_a_row),
        .fedp_b_col    (fedp_b_col),
        .fedp_c_val    (fedp_c_val),
        .fedp_d_val    (fedp_d_val)
`ifdef TCU_FEDP_SEQ_PERF_EN
        ,
        .perf_jobs     (perf_jobs),
        .perf_stall    (perf_stall)
`endif
    );

    // ---------------- fp32 helpers (normal numbers and zero only) ----------
    function automatic real fp2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:23]) - 127;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2fp(input real x);
        logic        s;
        int          e;
        real         v;
        logic [22:0] f;
        if (x == 0.0) return 32'd0;
        v = x;
        s = (v < 0.0);
        if (s) v = -v;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        f = 23'($rtoi((v - 1.0) * 8388608.0));
        return {s, 8'(e + 127), f};
    endfunction

    // FEDP function: c + sum over enabled lanes of a[i]*b[i].
    function automatic logic [31:0] fedp_fn(input logic [3:0] fmt, input logic [N*32-1:0] a,
                                            input logic [N*32-1:0] b, input logic [31:0] c,
                                            input logic [VMASK_W-1:0] m);
        real         sr;
        logic [31:0] si;
        logic [31:0] p;
        if (fmt == 4'd0) begin
            sr = fp2r(c);
            for (int i = 0; i < N; i++)
                if (m[i]) sr = sr + fp2r(a[i*32 +: 32]) * fp2r(b[i*32 +: 32]);
            return r2fp(sr);
        end
        si = c;
        for (int i = 0; i < N; i++) begin
            p = a[i*32 +: 32] * b[i*32 +: 32];
            if (m[i]) si = si + p;
        end
        return si;
    endfunction

    // ---------------- behavioural FEDP pipeline ----------------------------
    logic [31:0] pipe [LATENCY];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= 32'd0;
        end else if (fedp_enable) begin
            pipe[0] <= fedp_fn(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val, fedp_vld_mask);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fedp_d_val = pipe[LATENCY-1];

    // ---------------- checking ---------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int acc_cyc;
    int valid_cyc;

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_beat(input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                             input logic [31:0] c, input logic [3:0] fs, input logic [3:0] fd,
                             input logic [VMASK_W-1:0] m, input logic [TAG_W-1:0] t,
                             input logic last, output int waited);
        waited = 0;
        bus.in_a_row  = a;
        bus.in_b_col  = b;
        bus.in_c_init = c;
        bus.in_fmt_s  = fs;
        bus.in_fmt_d  = fd;
        bus.in_vmask  = m;
        bus.in_tag    = t;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, holds out_ready low for 'hold' cycles, then takes it.
    task automatic get_result(input int hold, output logic [31:0] d, output logic [TAG_W-1:0] t,
                              output logic e);
        int   n;
        logic stable;
`ifdef TCU_FEDP_SEQ_PERF_EN
        logic [31:0] st0;
        logic [31:0] jb0;
`endif
        n = 0;
        d = '0; t = '0; e = 1'b0;
        bus.out_ready = 1'b0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
            return;
        end
        valid_cyc = cyc;
        d = bus.out_data;
        t = bus.out_tag;
        e = bus.out_err;
`ifdef TCU_FEDP_SEQ_PERF_EN
        st0 = perf_stall;
        jb0 = perf_jobs;
`endif
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_data !== d || bus.out_tag !== t ||
                bus.out_err !== e || bus.in_ready) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 64'(stable), 64'd1);
`ifdef TCU_FEDP_SEQ_PERF_EN
        check("perf_stall_delta", 64'(perf_stall - st0), 64'(hold));
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_drop", 64'(bus.out_valid), 64'd0);
`ifdef TCU_FEDP_SEQ_PERF_EN
        check("perf_jobs_delta", 64'(perf_jobs - jb0), 64'd1);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] ONE2 = {32'h3F800000, 32'h3F800000};
    localparam logic [63:0] TWO2 = {32'h40000000, 32'h40000000};

    initial begin
        logic [31:0]      d, exp, c0;
        logic [TAG_W-1:0] t;
        logic             e;
        int               w, acc0;
        logic [N*32-1:0]  a, b;
        logic [VMASK_W-1:0] m;
        logic [3:0]       fs0;
        int               nb;

        bus.in_valid = 0; bus.in_a_row = '0; bus.in_b_col = '0; bus.in_c_init = '0;
        bus.in_fmt_s = '0; bus.in_fmt_d = '0; bus.in_vmask = '0; bus.in_tag = '0;
        bus.in_last = 0; bus.out_ready = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_err", 64'(bus.out_err), 64'd0);
        check("rst_vld_mask", 64'(fedp_vld_mask), 64'd0);
        check("rst_c_val", 64'(fedp_c_val), 64'd0);
        check("fedp_enable", 64'(fedp_enable), 64'd1);

        // Single beat fp32: 1*2 + 1*2 + 0 = 4.0, result 6 edges after accept
        send_beat(ONE2, TWO2, 32'h0, 4'd0, 4'd0, 8'h03, 8'hA1, 1'b1, w);
        check("single_vld_mask_first", 64'(fedp_vld_mask), 64'h03);
        @(negedge clk);
        check("single_vld_mask_after", 64'(fedp_vld_mask), 64'h00);
        get_result(0, d, t, e);
        check("single_latency", 64'(valid_cyc - acc_cyc), 64'(LATENCY + 2));
        check("single_data", 64'(d), 64'h40800000);
        check("single_tag", 64'(t), 64'hA1);
        check("single_err", 64'(e), 64'd0);

        // Two-beat fp32: 1 + 4 = 5, then 5 + 4 = 9
        send_beat(ONE2, TWO2, 32'h3F800000, 4'd0, 4'd0, 8'h03, 8'hB2, 1'b0, w);
        acc0 = acc_cyc;
        send_beat(ONE2, TWO2, 32'h0, 4'd0, 4'd0, 8'h03, 8'hB2, 1'b1, w);
        check("two_ready_low", 64'(w), 64'd5);
        check("two_spacing", 64'(acc_cyc - acc0), 64'(LATENCY + 2));
        check("two_c_val", 64'(fedp_c_val), 64'h40A00000);
        get_result(0, d, t, e);
        check("two_data", 64'(d), 64'h41100000);

        // Backpressure for 10 cycles
        send_beat(ONE2, TWO2, 32'h0, 4'd0, 4'd0, 8'h03, 8'hC3, 1'b1, w);
        get_result(10, d, t, e);
        check("bp_data", 64'(d), 64'h40800000);
        check("bp_tag", 64'(t), 64'hC3);

        // Format/tag latching: beat 2 changes fmt_s and tag
        a = {32'd3, 32'd5}; b = {32'd7, 32'd11};
        send_beat(a, b, 32'd100, 4'd1, 4'd2, 8'h03, 8'hD4, 1'b0, w);
        send_beat(a, b, 32'd0, 4'd0, 4'd9, 8'h01, 8'h99, 1'b1, w);
        check("latch_fmt_s", 64'(fedp_fmt_s), 64'd1);
        check("latch_fmt_d", 64'(fedp_fmt_d), 64'd2);
        get_result(0, d, t, e);
        check("latch_tag", 64'(t), 64'hD4);
        check("latch_data", 64'(d), 64'(32'd100 + 32'd76 + 32'd55));

        // Empty vmask: c passes through
        send_beat(a, b, 32'h12345678, 4'd1, 4'd0, 8'h00, 8'hE5, 1'b1, w);
        get_result(0, d, t, e);
        check("empty_mask_data", 64'(d), 64'h12345678);

        // Overflow: 8 beats without last -> err; beat 9 starts a new job
        c0 = $urandom;
        exp = c0;
        for (int i = 0; i < MAX_STEPS; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; m = 8'($urandom_range(0, 255));
            exp = fedp_fn(4'd1, a, b, exp, m);
            send_beat(a, b, c0, 4'd1, 4'd0, m, 8'h55, 1'b0, w);
        end
        get_result(0, d, t, e);
        check("ovf_data", 64'(d), 64'(exp));
        check("ovf_err", 64'(e), 64'd1);
        check("ovf_tag", 64'(t), 64'h55);
        c0 = $urandom;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        exp = fedp_fn(4'd1, c0 == 0 ? a : a, b, c0, 8'h03);
        send_beat(a, b, c0, 4'd1, 4'd0, 8'h03, 8'h66, 1'b0, w);
        repeat (12) @(negedge clk);   // idle in ISSUE; accumulator must survive
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        exp = fedp_fn(4'd1, a, b, exp, 8'h02);
        send_beat(a, b, 32'hDEAD, 4'd0, 4'd0, 8'h02, 8'h77, 1'b1, w);
        get_result(0, d, t, e);
        check("ovf_next_data", 64'(d), 64'(exp));
        check("ovf_next_tag", 64'(t), 64'h66);
        check("ovf_next_err", 64'(e), 64'd0);

        // Reset in WAIT of beat 2
        send_beat(ONE2, TWO2, 32'h3F800000, 4'd0, 4'd0, 8'h03, 8'h11, 1'b0, w);
        send_beat(ONE2, TWO2, 32'h0, 4'd0, 4'd0, 8'h03, 8'h11, 1'b1, w);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_vld_mask", 64'(fedp_vld_mask), 64'd0);
        send_beat(ONE2, TWO2, 32'h40000000, 4'd0, 4'd0, 8'h01, 8'h22, 1'b1, w);
        get_result(0, d, t, e);
        check("midrst_data", 64'(d), 64'h40800000);
        check("midrst_tag", 64'(t), 64'h22);

        // Randomized integer jobs with random gaps and backpressure
        for (int j = 0; j < 20; j++) begin
            nb = $urandom_range(1, 4);
            c0 = $urandom;
            fs0 = 4'($urandom_range(1, 15));
            exp = c0;
            for (int k = 0; k < nb; k++) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                m = 8'($urandom_range(0, 255));
                exp = fedp_fn(fs0, a, b, exp, m);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(a, b, k == 0 ? c0 : $urandom, k == 0 ? fs0 : 4'($urandom_range(0, 15)),
                          4'd0, m, k == 0 ? 8'(j) : 8'($urandom), k == nb - 1, w);
            end
            get_result($urandom_range(0, 3), d, t, e);
            check("rnd_data", 64'(d), 64'(exp));
            check("rnd_tag", 64'(t), 64'(j));
            check("rnd_err", 64'(e), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
